// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one synchronous-read memory port between instruction
//             fetch and data load/store. Data has priority. An optional
//             starvation guard is enabled by defining MEMARB_STARVE_GUARD_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int WORD         = 32,
   parameter int ADDR         = 16,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req_i,
   input  logic [ADDR-1:0] if_addr_i,
   input  logic            if_flush_i,
   output logic            if_stall_o,
   output logic            if_v_o,
   output logic [WORD-1:0] if_inst_o,
   output logic [ADDR-1:0] if_origaddr_o,
   input  logic            d_req_i,
   input  logic            d_we_i,
   input  logic [ADDR-1:0] d_addr_i,
   input  logic [WORD-1:0] d_wdata_i,
   output logic            d_stall_o,
   output logic            d_v_o,
   output logic [WORD-1:0] d_rdata_o,
   output logic [ADDR-1:0] mem_a_o,
   output logic            mem_w_o,
   output logic [WORD-1:0] mem_d_o,
   input  logic [WORD-1:0] mem_q_i
);

   typedef enum logic [1:0] {
      RESP_NONE = 2'd0,
      RESP_IF   = 2'd1,
      RESP_DRD  = 2'd2,
      RESP_DWR  = 2'd3
   } resp_t;

   resp_t           r_resp;
   logic [ADDR-1:0] r_mem_a;
   logic [ADDR-1:0] r_if_origaddr;
   logic            w_force_if;
   logic            w_d_gnt;
   logic            w_if_gnt;

`ifdef MEMARB_STARVE_GUARD_EN
   localparam logic [2:0] c_starve_limit = 3'(STARVE_LIMIT);

   logic [2:0] r_starve;

   // Counts consecutive data grants that left a waiting fetch behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve <= 3'd0;
      end else if (w_if_gnt || !if_req_i) begin
         r_starve <= 3'd0;
      end else if (w_d_gnt) begin
         r_starve <= r_starve + 3'd1;
      end
   end

   assign w_force_if = (r_starve == c_starve_limit) & if_req_i;
`else
   // Strict data priority; the limit is only meaningful with the guard.
   assign w_force_if = (STARVE_LIMIT < 0);
`endif

   assign w_d_gnt    = d_req_i & ~w_force_if;
   assign w_if_gnt   = if_req_i & (~d_req_i | w_force_if);
   assign if_stall_o = if_req_i & ~w_if_gnt;
   assign d_stall_o  = d_req_i & ~w_d_gnt;

   always_comb begin
      mem_a_o = r_mem_a;
      mem_w_o = 1'b0;
      mem_d_o = d_wdata_i;
      if (w_d_gnt) begin
         mem_a_o = d_addr_i;
         mem_w_o = d_we_i;
      end else if (w_if_gnt) begin
         mem_a_o = if_addr_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_resp        <= RESP_NONE;
         r_mem_a       <= '0;
         r_if_origaddr <= '0;
      end else begin
         r_mem_a <= mem_a_o;
         if (w_if_gnt) begin
            r_resp        <= RESP_IF;
            r_if_origaddr <= if_addr_i;
         end else if (w_d_gnt) begin
            r_resp <= d_we_i ? RESP_DWR : RESP_DRD;
         end else begin
            r_resp <= RESP_NONE;
         end
      end
   end

   // A response still in flight while reset is asserted is dropped.
   assign if_v_o        = (r_resp == RESP_IF) & ~if_flush_i & ~rst;
   assign d_v_o         = ((r_resp == RESP_DRD) | (r_resp == RESP_DWR)) & ~rst;
   assign if_inst_o     = mem_q_i;
   assign d_rdata_o     = mem_q_i;
   assign if_origaddr_o = r_if_origaddr;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter with a memory and a
//             reference model of the arbitration rules.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;
   localparam int WORD  = 32;
   localparam int ADDR  = 16;
   localparam int LIMIT = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            if_req, if_flush, d_req, d_we;
   logic [ADDR-1:0] if_addr, d_addr;
   logic [WORD-1:0] d_wdata;
   logic            if_stall, if_v, d_stall, d_v, mem_w;
   logic [WORD-1:0] if_inst, d_rdata, mem_d;
   logic [WORD-1:0] mem_q = '0;
   logic [ADDR-1:0] if_origaddr, mem_a;

   always #5 clk = ~clk;

   mem_arbiter #(.WORD(WORD), .ADDR(ADDR), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
      .if_stall_o(if_stall), .if_v_o(if_v), .if_inst_o(if_inst),
      .if_origaddr_o(if_origaddr),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_stall_o(d_stall), .d_v_o(d_v), .d_rdata_o(d_rdata),
      .mem_a_o(mem_a), .mem_w_o(mem_w), .mem_d_o(mem_d), .mem_q_i(mem_q)
   );

   // Environment memory, read-first, one-cycle read latency.
   logic [WORD-1:0] env_mem [0:65535];
   logic [WORD-1:0] ref_mem [0:65535];

   always @(posedge clk) begin
      if (mem_w) env_mem[mem_a] <= mem_d;
      mem_q <= env_mem[mem_a];
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: pending response kind 0=none 1=fetch 2=load 3=store.
   int              m_pend   = 0;
   int              m_starve = 0;
   logic [ADDR-1:0] m_orig   = '0;
   logic [ADDR-1:0] m_hold   = '0;
   logic [WORD-1:0] m_pdata  = '0;

   function automatic logic [1:0] grant();
      logic fi;
`ifdef MEMARB_STARVE_GUARD_EN
      fi = (m_starve == LIMIT) && if_req;
`else
      fi = 1'b0;
`endif
      return {d_req & ~fi, if_req & (~d_req | fi)};
   endfunction

   always @(posedge clk) begin
      logic [1:0]      g;
      logic [ADDR-1:0] a;
      g = grant();
      a = g[1] ? d_addr : (g[0] ? if_addr : m_hold);
      if (rst) begin
         m_pend = 0; m_orig = '0; m_hold = '0; m_starve = 0;
      end else begin
         m_pend  = g[0] ? 1 : (g[1] ? (d_we ? 3 : 2) : 0);
         m_pdata = ref_mem[a];
         m_hold  = a;
         if (g[0]) m_orig = if_addr;
         if (g[0] || !if_req) m_starve = 0;
         else if (g[1]) m_starve = m_starve + 1;
      end
      if (g[1] && d_we) ref_mem[d_addr] = d_wdata;
   end

   always @(negedge clk) begin
      logic [1:0]      g;
      logic [ADDR-1:0] a;
      g = grant();
      a = g[1] ? d_addr : (g[0] ? if_addr : m_hold);
      chk("m_if_stall", 32'(if_stall), 32'(if_req & ~g[0]));
      chk("m_d_stall", 32'(d_stall), 32'(d_req & ~g[1]));
      chk("m_mem_w", 32'(mem_w), 32'(g[1] & d_we));
      chk("m_mem_a", 32'(mem_a), 32'(a));
      if (g[1] && d_we) chk("m_mem_d", mem_d, d_wdata);
      chk("m_if_v", 32'(if_v), 32'((m_pend == 1) && !if_flush && !rst));
      chk("m_d_v", 32'(d_v), 32'((m_pend >= 2) && !rst));
      chk("m_origaddr", 32'(if_origaddr), 32'(m_orig));
      if (m_pend == 1 && !rst) chk("m_if_inst", if_inst, m_pdata);
      if (m_pend == 2 && !rst) chk("m_d_rdata", d_rdata, m_pdata);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; if_req = 1'b0; if_flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      for (int i = 0; i < 65536; i++) begin
         env_mem[i] = {16'hC0DE, 16'(i)};
         ref_mem[i] = {16'hC0DE, 16'(i)};
      end
      for (int i = 0; i < 3; i++) begin
         env_mem[16'h0010 + i] = 32'hA0 + i;
         ref_mem[16'h0010 + i] = 32'hA0 + i;
      end

      @(negedge clk);
      chk("rst_if_v", 32'(if_v), 0);
      chk("rst_d_v", 32'(d_v), 0);
      chk("rst_origaddr", 32'(if_origaddr), 0);
      chk("rst_mem_w", 32'(mem_w), 0);
      tick();
      rst = 1'b0;
      tick();

      // Fetch only, back to back.
      if_req = 1'b1; if_addr = 16'h0010;
      @(negedge clk); chk("fo_stall0", 32'(if_stall), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i < 2) if_addr = 16'h0011 + 16'(i); else if_req = 1'b0;
         @(negedge clk);
         chk("fo_v", 32'(if_v), 1);
         chk("fo_inst", if_inst, 32'hA0 + i);
         chk("fo_orig", 32'(if_origaddr), 32'h10 + i);
         chk("fo_stall", 32'(if_stall), 0);
      end
      tick();

      // Store then load.
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 32'hDEADBEEF;
      @(negedge clk); chk("st_w", 32'(mem_w), 1);
      tick(); d_we = 1'b0;
      @(negedge clk); chk("st_v", 32'(d_v), 1); chk("ld_w", 32'(mem_w), 0);
      tick(); d_req = 1'b0;
      @(negedge clk); chk("ld_v", 32'(d_v), 1); chk("ld_data", d_rdata, 32'hDEADBEEF);
      tick();

      // Conflict.
      if_req = 1'b1; if_addr = 16'h0030; d_req = 1'b1; d_addr = 16'h0200;
      @(negedge clk); chk("cf_if_stall", 32'(if_stall), 1); chk("cf_d_stall", 32'(d_stall), 0);
      tick(); d_req = 1'b0;
      @(negedge clk); chk("cf_if_gnt", 32'(if_stall), 0); chk("cf_d_v", 32'(d_v), 1);
      tick(); if_req = 1'b0;
      @(negedge clk); chk("cf_if_v", 32'(if_v), 1); chk("cf_orig", 32'(if_origaddr), 32'h30);
      tick();

      // Flush of a returning fetch.
      if_req = 1'b1; if_addr = 16'h0020;
      tick(); if_req = 1'b0; if_flush = 1'b1;
      @(negedge clk);
      chk("fl_v", 32'(if_v), 0);
      chk("fl_orig", 32'(if_origaddr), 32'h20);
      chk("fl_inst", if_inst, 32'hC0DE0020);
      tick(); if_flush = 1'b0;

      // Reset mid-operation, with a store granted during reset.
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
      tick(); rst = 1'b1; d_we = 1'b1; d_addr = 16'h0050; d_wdata = 32'h12345678;
      @(negedge clk); chk("rs_d_v0", 32'(d_v), 0); chk("rs_st_w", 32'(mem_w), 1);
      tick(); rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk); chk("rs_d_v1", 32'(d_v), 0); chk("rs_orig", 32'(if_origaddr), 0);
      tick();
      d_req = 1'b1; d_addr = 16'h0050;
      tick(); d_req = 1'b0;
      @(negedge clk); chk("rs_ld_data", d_rdata, 32'h12345678);
      tick();

      // Starvation: both requesters continuous for 20 cycles.
      if_req = 1'b1; if_addr = 16'h0060; d_req = 1'b1; d_addr = 16'h0070;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
`ifdef MEMARB_STARVE_GUARD_EN
         chk("sv_d_stall", 32'(d_stall), 32'((k % 5) == 4));
         chk("sv_if_stall", 32'(if_stall), 32'((k % 5) != 4));
`else
         chk("sv_if_stall", 32'(if_stall), 1);
         chk("sv_d_stall", 32'(d_stall), 0);
`endif
         tick();
      end
      if_req = 1'b0; d_req = 1'b0;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one `DP_mem32x64k` instance between the instruction-fetch requester (`ifetch`) and the data-access requester (load/store from `execute`). It sits in `core` between those stages and the memory. It grants at most one access per cycle, drives the memory address, write-enable and write-data lines, and steers the one-cycle-later read data back to the requester that issued it. Data accesses have priority. An optional starvation guard guarantees that instruction fetch makes forward progress.

## Interface
- `WORD`, 32, data width (matches `` `WORD ``)
- `ADDR`, 16, address width (matches `` `ADDR ``, 64k words)
- `STARVE_LIMIT`, 4, number of consecutive data grants allowed while fetch waits (guard build only)
- `clk` input 1 — clock; single clock domain
- `rst` input 1 — synchronous, active-high reset
- `if_req_i` input 1 — fetch request; held with `if_addr_i` stable until granted
- `if_addr_i` input ADDR — fetch address
- `if_flush_i` input 1 — kill the fetch response returning this cycle (branch redirect)
- `if_stall_o` output 1 — `if_req_i & ~if_gnt`; combinational
- `if_v_o` output 1 — fetch data valid
- `if_inst_o` output WORD — fetched word; equals `mem_q_i`
- `if_origaddr_o` output ADDR — address of the word on `if_inst_o` (registered)
- `d_req_i` input 1 — data request; held stable until granted
- `d_we_i` input 1 — 1 = store, 0 = load
- `d_addr_i` input ADDR — data address
- `d_wdata_i` input WORD — store data
- `d_stall_o` output 1 — `d_req_i & ~d_gnt`; combinational
- `d_v_o` output 1 — data access complete; for loads, `d_rdata_o` is valid
- `d_rdata_o` output WORD — load data; equals `mem_q_i`
- `mem_a_o` output ADDR — memory address
- `mem_w_o` output 1 — memory write enable
- `mem_d_o` output WORD — memory write data
- `mem_q_i` input WORD — memory read data; synchronous read, valid the cycle after the address

## Operation
- **Grant (combinational, same cycle):**
  - `d_gnt = d_req_i & ~force_if`.
  - `if_gnt = if_req_i & (~d_req_i | force_if)`.
  - `force_if` is 0 unless the guard is compiled in.
- **Memory drive:**
  - On `d_gnt`: `mem_a_o=d_addr_i`, `mem_w_o=d_we_i`, `mem_d_o=d_wdata_i`.
  - On `if_gnt`: `mem_a_o=if_addr_i`, `mem_w_o=0`.
  - With no grant: `mem_a_o` holds its last value and `mem_w_o=0`.
  - `mem_w_o` is never 1 without `d_gnt`.
- **Response tracking:** state register `resp` takes one of `NONE`, `IF`, `DRD`, `DWR`.
  - It is loaded every cycle from the current grant: `IF` on `if_gnt`, `DRD`/`DWR` on `d_gnt` by `d_we_i`, `NONE` otherwise.
  - `if_origaddr_o` is loaded with `if_addr_i` on `if_gnt`.
- **Response outputs:**
  - `if_v_o = (resp==IF) & ~if_flush_i`.
  - `d_v_o = (resp==DRD) | (resp==DWR)`.
  - `d_rdata_o` is meaningful only when `resp==DRD`.
- **No back-pressure:** responses cannot be stalled; each requester must accept a response in its return cycle.
- **Pipelining:** full back-to-back throughput. A requester may present its next request in the same cycle its previous response returns.
- **Flush:**
  - `if_flush_i` suppresses only a returning fetch response. It does not affect a grant made in the same cycle.
  - The requester deasserts or changes `if_req_i` itself.
- **Reset:**
  - Clears `resp` to `NONE`, `if_origaddr_o` to 0, `mem_a_o` hold register to 0, and the starvation counter to 0.
  - An in-flight response at reset is dropped: no `v` pulse in the following cycle.
  - A store granted in the same cycle as `rst` is still issued to memory. The grant is combinational; `rst` only gates the registers.

## Timing
- Request→response latency is exactly 1 cycle after grant.
- Grant and stall are combinational from the request inputs, with zero cycles to grant.
- Stores complete in the grant cycle (memory write edge). `d_v_o` pulses the next cycle.
- Reset values:
  - `if_v_o=0`, `d_v_o=0`, `if_origaddr_o=0`.
  - `mem_w_o=0` when no request is present.
  - `if_inst_o`/`d_rdata_o` follow `mem_q_i` (don't-care while the matching `v` is 0).
- Simultaneous `if_req_i` and `d_req_i`: data wins unless `force_if`. The loser stalls and retries next cycle.

## Configuration
- **`MEMARB_STARVE_GUARD_EN` defined:**
  - A 3-bit counter `starve` increments on each `d_gnt` while `if_req_i=1`.
  - It clears on `if_gnt` or whenever `if_req_i=0`.
  - `force_if = (starve == STARVE_LIMIT) & if_req_i`. This grants fetch for one cycle and stalls data.
- **Not defined:** strict data priority. `force_if=0`, no counter exists, and fetch can starve indefinitely.

## Test plan
- **Fetch only:** `if_req_i=1`, addresses 0x0010, 0x0011, 0x0012 back-to-back, preloaded 0xA0, 0xA1, 0xA2.
  - Required: `if_v_o=1` on cycles 1–3 with `if_inst_o`=0xA0/0xA1/0xA2 and `if_origaddr_o`=0x0010/11/12.
  - Required: `if_stall_o=0` throughout.
- **Store then load:** store 0xDEADBEEF to 0x0100, then load 0x0100.
  - Required: `mem_w_o=1` only in the store cycle, and `d_v_o` pulses twice.
  - Required: second pulse `d_rdata_o=0xDEADBEEF`.
- **Conflict:** `if_req_i` and `d_req_i` (load 0x0200) in the same cycle.
  - Required: `if_stall_o=1` and `d_stall_o=0` that cycle.
  - Required: fetch is granted next cycle and `if_v_o` arrives two cycles after the request.
- **Flush:** fetch granted at 0x0020, `if_flush_i=1` in the return cycle.
  - Required: `if_v_o=0` in the return cycle, with no other output disturbed.
- **Reset mid-operation:** assert `rst` in the cycle after a load grant.
  - Required: `d_v_o=0` that cycle and the next.
  - Required: `if_origaddr_o=0` the cycle after `rst`.
- **Starvation, guard built, `STARVE_LIMIT=4`:** `d_req_i` continuous, `if_req_i` continuous.
  - Required: data granted 4 cycles, fetch granted on the 5th with `d_stall_o=1`, then the pattern repeats.
  - Required without the macro: `if_stall_o` stays 1 for all 20 cycles run.
